io_rx_fifo: RTL and testbench

Light8080 I/O-space responder that buffers UART receive bytes in a circular FIFO and exposes them to the CPU through the data and status registers at 0x80/0x83. It replaces the single-byte `rxfull` flag in the SoC. It sits in the CPU clock domain, after the UART-to-CPU flag crossing, and drives the CPU's I/O read-data mux. Overrun is detected and reported instead of silently overwriting.

---
 rtl/io_rx_fifo.sv | 157 +++++++++++++++
 tb/tb_io_rx_fifo.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_rx_fifo.sv
// Purpose : Light8080 I/O responder that queues UART receive bytes and serves them at DATA_ADDR/STAT_ADDR.
// Latency : a push is visible in status/head 1 cycle later; io_dout is registered, 1 cycle after address.
// Backpressure: none upstream; a push into a full FIFO is dropped and latches the sticky ovr flag.
//
// Ports:
//   clk, rstb                 CPU clock, asynchronous active-low reset
//   rx_valid, rx_data         single-cycle receive strobe and byte (already in clk domain)
//   tx_busy                   transmitter busy, reported in status bit 0
//   cpu_addr/io/rd/wr/dout    CPU I/O bus (low address byte, qualifiers, write data)
//   io_dout                   registered read data to the CPU input mux
//   rx_irq                    level interrupt request (0 unless IO_RX_FIFO_IRQ_EN)
//
// Build option: define IO_RX_FIFO_IRQ_EN to add the irq_en register (status/control bit 6)
// and the registered rx_irq output.
//
// Status byte: {flush(0), irq_en, 0, not_empty, ovr, full, 0, tx_busy}
// Control write (STAT_ADDR): bit7 flush, bit6 irq_en, bit3 clear ovr.

module io_rx_fifo #(
    parameter int          DEPTH_LOG2 = 4,
    parameter logic [7:0]  DATA_ADDR  = 8'h80,
    parameter logic [7:0]  STAT_ADDR  = 8'h83
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       tx_busy,
    input  logic [7:0] cpu_addr,
    input  logic       cpu_io,
    input  logic       cpu_rd,
    input  logic       cpu_wr,
    input  logic [7:0] cpu_dout,
    output logic [7:0] io_dout,
    output logic       rx_irq
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  ovr_q, ovr_d;
    logic                  rd_hit_q;
    logic [7:0]            io_dout_q, io_dout_d;

    logic       rd_hit, stat_wr, flush, clr_ovr;
    logic       empty, full, pop, push_ok, ovr_set;
    logic       irq_en_bit;
    logic [7:0] head, status;

    assign rd_hit  = cpu_io & cpu_rd & (cpu_addr == DATA_ADDR);
    assign stat_wr = cpu_io & cpu_wr & (cpu_addr == STAT_ADDR);
    assign flush   = stat_wr & cpu_dout[7];
    assign clr_ovr = stat_wr & cpu_dout[3];

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_FULL);

    // Pop on the falling edge of the read decode, so the head byte is stable
    // for however long the CPU holds rd, and each read pops exactly once.
    assign pop = rd_hit_q & ~rd_hit & ~empty;

    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    // A flush discards any coincident push and does not count it as an overrun.
    assign push_ok = rx_valid & (~full | pop) & ~flush;
    assign ovr_set = rx_valid & full & ~pop & ~flush;

    assign head   = empty ? 8'h00 : mem[rptr_q];
    assign status = {1'b0, irq_en_bit, 1'b0, ~empty, ovr_q, full, 1'b0, tx_busy};

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        io_dout_d = io_dout_q;

        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) wptr_d = wptr_q + PTR_ONE;
            if (pop)     rptr_d = rptr_q + PTR_ONE;
            if (push_ok && !pop)      count_d = count_q + CNT_ONE;
            else if (pop && !push_ok) count_d = count_q - CNT_ONE;
        end

        // A byte lost in the same cycle as a clear is still reported.
        ovr_d = (ovr_q & ~clr_ovr) | ovr_set;

        if (cpu_io && (cpu_addr == DATA_ADDR))      io_dout_d = head;
        else if (cpu_io && (cpu_addr == STAT_ADDR)) io_dout_d = status;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            ovr_q     <= 1'b0;
            rd_hit_q  <= 1'b0;
            io_dout_q <= 8'h00;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            ovr_q     <= ovr_d;
            rd_hit_q  <= rd_hit;
            io_dout_q <= io_dout_d;
        end
    end

    // Storage needs no reset: only entries below count are ever presented.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr_q] <= rx_data;
    end

    assign io_dout = io_dout_q;

`ifdef IO_RX_FIFO_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic rx_irq_q, rx_irq_d;

    always_comb begin
        irq_en_d = stat_wr ? cpu_dout[6] : irq_en_q;
        rx_irq_d = irq_en_q & (~empty | ovr_q);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            irq_en_q <= 1'b0;
            rx_irq_q <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            rx_irq_q <= rx_irq_d;
        end
    end

    assign irq_en_bit = irq_en_q;
    assign rx_irq     = rx_irq_q;

    logic unused_cpu_dout_bits;
    assign unused_cpu_dout_bits = ^{cpu_dout[5:4], cpu_dout[2:0]};
`else
    assign irq_en_bit = 1'b0;
    assign rx_irq     = 1'b0;

    logic unused_cpu_dout_bits;
    assign unused_cpu_dout_bits = ^{cpu_dout[6:4], cpu_dout[2:0]};
`endif

endmodule

// File: tb/tb_io_rx_fifo.sv
module tb_io_rx_fifo;

    logic       clk;
    logic       rstb;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_busy;
    logic [7:0] cpu_addr;
    logic       cpu_io;
    logic       cpu_rd;
    logic       cpu_wr;
    logic [7:0] cpu_dout;
    logic [7:0] io_dout;
    logic       rx_irq;

    io_rx_fifo dut (
        .clk      (clk),
        .rstb     (rstb),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .tx_busy  (tx_busy),
        .cpu_addr (cpu_addr),
        .cpu_io   (cpu_io),
        .cpu_rd   (cpu_rd),
        .cpu_wr   (cpu_wr),
        .cpu_dout (cpu_dout),
        .io_dout  (io_dout),
        .rx_irq   (rx_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: stimulus queues expectations, monitor pops on each sample request.
    string      name_q [$];
    bit         sel_q  [$];   // 0: io_dout, 1: rx_irq
    logic [7:0] exp_q  [$];
    logic       smp_req;

    int checks;
    int errors;

    string      mon_nm;
    bit         mon_sel;
    logic [7:0] mon_exp;
    logic [7:0] mon_act;

    always @(negedge clk) begin
        if (smp_req) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty: sample requested with no expectation queued");
            end else begin
                mon_nm  = name_q.pop_front();
                mon_sel = sel_q.pop_front();
                mon_exp = exp_q.pop_front();
                mon_act = mon_sel ? {7'b0, rx_irq} : io_dout;
                checks++;
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL %s: got %02h expected %02h", mon_nm, mon_act, mon_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input string nm, input bit sel, input logic [7:0] exp);
        name_q.push_back(nm);
        sel_q.push_back(sel);
        exp_q.push_back(exp);
        smp_req = 1'b1;
        @(negedge clk);
        #1;
        smp_req = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wr_stat(input logic [7:0] v, input bit with_push, input logic [7:0] pb);
        cpu_io   = 1'b1;
        cpu_addr = 8'h83;
        cpu_wr   = 1'b1;
        cpu_dout = v;
        rx_valid = with_push;
        rx_data  = pb;
        tick();
        cpu_wr   = 1'b0;
        cpu_io   = 1'b0;
        rx_valid = 1'b0;
    endtask

    // Read cycle held for 'hold' edges; optional push lands on the pop edge.
    task automatic rd_reg(input logic [7:0] addr, input logic [7:0] exp, input string nm,
                          input int hold, input bit push_at_pop, input logic [7:0] pb);
        cpu_io   = 1'b1;
        cpu_addr = addr;
        cpu_rd   = 1'b1;
        tick();
        expect_now(nm, 1'b0, exp);
        repeat (hold - 1) @(posedge clk);
        #1;
        cpu_rd   = 1'b0;
        cpu_io   = 1'b0;
        rx_valid = push_at_pop;
        rx_data  = pb;
        tick();
        rx_valid = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        smp_req  = 1'b0;
        rstb     = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_busy  = 1'b0;
        cpu_addr = 8'h00;
        cpu_io   = 1'b0;
        cpu_rd   = 1'b0;
        cpu_wr   = 1'b0;
        cpu_dout = 8'h00;

        // Reset values
        expect_now("reset_io_dout", 1'b0, 8'h00);
        expect_now("reset_rx_irq", 1'b1, 8'h00);
        rstb = 1'b1;
        tick();

        // Empty reads: status 0, data 0, no underflow
        rd_reg(8'h83, 8'h00, "empty_status", 1, 1'b0, 8'h00);
        rd_reg(8'h80, 8'h00, "empty_data", 2, 1'b0, 8'h00);
        rd_reg(8'h83, 8'h00, "empty_status_after_read", 1, 1'b0, 8'h00);
        rd_reg(8'h80, 8'h00, "empty_data_again", 1, 1'b0, 8'h00);

        // Three bytes, rd held three cycles each
        push(8'h41);
        push(8'h42);
        push(8'h43);
        tx_busy = 1'b1;
        rd_reg(8'h83, 8'h11, "status_tx_busy_not_empty", 1, 1'b0, 8'h00);
        tx_busy = 1'b0;
        rd_reg(8'h80, 8'h41, "read_41", 3, 1'b0, 8'h00);
        rd_reg(8'h80, 8'h42, "read_42", 3, 1'b0, 8'h00);
        rd_reg(8'h80, 8'h43, "read_43", 3, 1'b0, 8'h00);
        rd_reg(8'h83, 8'h00, "status_drained", 1, 1'b0, 8'h00);

        // Overrun: 17 pushes into 16 slots
        for (int i = 0; i < 17; i++) push(8'(i));
        rd_reg(8'h83, 8'h1C, "status_full_ovr", 1, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) rd_reg(8'h80, 8'(i), "ovr_drain", 2, 1'b0, 8'h00);
        rd_reg(8'h83, 8'h08, "status_ovr_only", 1, 1'b0, 8'h00);
        wr_stat(8'h08, 1'b0, 8'h00);
        rd_reg(8'h83, 8'h00, "status_ovr_cleared", 1, 1'b0, 8'h00);

        // Full with coincident push and pop
        for (int i = 0; i < 16; i++) push(8'(8'hA0 + i));
        rd_reg(8'h83, 8'h14, "status_full", 1, 1'b0, 8'h00);
        rd_reg(8'h80, 8'hA0, "full_pop_with_push", 2, 1'b1, 8'h55);
        rd_reg(8'h83, 8'h14, "status_full_no_ovr", 1, 1'b0, 8'h00);
        for (int i = 1; i < 16; i++) rd_reg(8'h80, 8'(8'hA0 + i), "full_drain", 1, 1'b0, 8'h00);
        rd_reg(8'h80, 8'h55, "coincident_push_last", 1, 1'b0, 8'h00);
        rd_reg(8'h83, 8'h00, "status_after_full_drain", 1, 1'b0, 8'h00);

        // Flush, with a coincident push that must be discarded
        for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
        wr_stat(8'h80, 1'b1, 8'hEE);
        rd_reg(8'h83, 8'h00, "status_after_flush", 1, 1'b0, 8'h00);
        rd_reg(8'h80, 8'h00, "data_after_flush", 1, 1'b0, 8'h00);
        push(8'h99);
        rd_reg(8'h80, 8'h99, "push_after_flush", 1, 1'b0, 8'h00);

        // Pointer wrap
        for (int i = 0; i < 40; i++) begin
            push(8'(8'h30 + i));
            rd_reg(8'h80, 8'(8'h30 + i), "wrap", 1, 1'b0, 8'h00);
        end

        // Interrupt
        wr_stat(8'h40, 1'b0, 8'h00);
`ifdef IO_RX_FIFO_IRQ_EN
        rd_reg(8'h83, 8'h40, "status_irq_en", 1, 1'b0, 8'h00);
        push(8'h7E);
        expect_now("irq_low_first_cycle", 1'b1, 8'h00);
        tick();
        expect_now("irq_rise", 1'b1, 8'h01);
        tick();
        rd_reg(8'h80, 8'h7E, "irq_read_7e", 1, 1'b0, 8'h00);
        expect_now("irq_still_high_after_pop", 1'b1, 8'h01);
        tick();
        expect_now("irq_fall", 1'b1, 8'h00);
        tick();
`else
        rd_reg(8'h83, 8'h00, "status_irq_bit_absent", 1, 1'b0, 8'h00);
        push(8'h7E);
        tick();
        expect_now("irq_tied_low", 1'b1, 8'h00);
        tick();
        rd_reg(8'h80, 8'h7E, "irq_read_7e", 1, 1'b0, 8'h00);
`endif
        wr_stat(8'h00, 1'b0, 8'h00);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
